// File: rtl/regfile_read_ports.sv
// Register file with NREG entries of WIDTH bits and two independent registered read ports.
// Reads see same-cycle writes through a bypass; register ZERO_REG always reads as zero.
module regfile_read_ports #(
    parameter int WIDTH    = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 31,
    localparam int AW      = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    output logic             rd_valid_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_b
);

    localparam logic [AW-1:0] ZERO_IDX = ZERO_REG[AW-1:0];

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    // Storage: enable-gated flops; the zero register is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every entry is cleared on reset, so the array must stay as flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_IDX)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand selection: zero register first, then same-cycle write bypass, then stored value.
    always_comb begin
        // NOTE: defaults are assigned first with blocking '=' so no path leaves an output unassigned (no latch).
        opnd_a = regs[rd_addr_a];
        if (rd_addr_a == ZERO_IDX) begin
            opnd_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            opnd_a = wr_data;
        end
    end

    always_comb begin
        opnd_b = regs[rd_addr_b];
        if (rd_addr_b == ZERO_IDX) begin
            opnd_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            opnd_b = wr_data;
        end
    end

    // Read data holds its last value when no read is requested; only valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            if (rd_en_a) begin
                rd_data_a <= opnd_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_b <= rd_en_b;
            if (rd_en_b) begin
                rd_data_b <= opnd_b;
            end
        end
    end

endmodule

// File: doc/regfile_read_ports.md
Name: regfile_read_ports

Overview:
- 32-entry register file that owns the storage array and its two synchronous read ports for the 64-bit pipeline.
- Storage is a bank of enable-gated flops that hold their value when the write enable is low.
- The block delivers operands from that storage to the decode/execute boundary.
- Provides registered read data with read-enable/valid handshake, write-to-read bypass, and a hard-wired zero register (X31).

Parameters:
- WIDTH, 64, data width of each register and each read/write port.
- NREG, 32, number of architectural registers; must be a power of two; address width is log2(NREG).
- ZERO_REG, 31, index of the register that always reads zero and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write enable; register wr_addr loads wr_data at the clk edge when high.
- wr_addr  input  log2(NREG)  write address.
- wr_data  input  WIDTH  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  log2(NREG)  read address, port A.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_valid_a  output  1  high for exactly the cycle after an accepted rd_en_a.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: identical to port A, for port B.

Behaviour:
- Reset (reset=0, asynchronous):
  - All NREG registers clear to 0.
  - rd_data_a/b clear to 0; rd_valid_a/b clear to 0.
  - Takes effect immediately, independent of clk.
  - A write or read in flight when reset asserts is discarded.
  - The first accepted operation after release is at the first rising edge with reset=1.
- Write:
  - At a rising edge with wr_en=1 and wr_addr!=ZERO_REG, reg[wr_addr] <= wr_data.
  - wr_en=0 leaves every register unchanged.
  - A write to ZERO_REG is dropped silently.
- Read (per port, ports fully independent):
  - At a rising edge with rd_en=1, rd_data <= value(rd_addr) and rd_valid <= 1. Latency is 1 cycle from request to data.
  - At a rising edge with rd_en=0, rd_valid <= 0 and rd_data holds its previous value (not cleared).
  - Back-to-back requests give one valid result per cycle; no stall and no backpressure.
- value(addr) rules, in priority order:
  - addr==ZERO_REG -> 0, even if a write to ZERO_REG is presented the same cycle.
  - wr_en=1 and wr_addr==addr in the same cycle -> wr_data (bypass: new data, not old).
  - Otherwise -> reg[addr].
- Both ports reading the same address in the same cycle receive identical data.
- Out-of-range addresses cannot occur because NREG is a power of two.
- Data passes through unmodified: no sign extension, no truncation.

Test Plan:
- Reset: drive reset=0 mid-run with rd_valid_a=1 -> all outputs 0 immediately, before the next clk edge. After release, reading each of regs 0..30 returns 0.
- Write then read: write reg5=0x0123_4567_89AB_CDEF; next cycle rd_en_a=1, rd_addr_a=5 -> one cycle later rd_data_a=0x0123456789ABCDEF and rd_valid_a=1. The following cycle with rd_en_a=0 -> rd_valid_a=0 and rd_data_a unchanged.
- Bypass: reg7 holds 0xAAAA; in the same cycle, write reg7=0x5555 and rd_en_b=1 with rd_addr_b=7 -> rd_data_b=0x5555 one cycle later. Port A reading reg7 in that same cycle also returns 0x5555.
- Zero register: write reg31=0xFFFF_FFFF_FFFF_FFFF while both ports read 31 in the same cycle -> both ports return 0. A later read of 31 also returns 0.
- Write enable low: wr_en=0, wr_addr=3, wr_data=0xDEAD -> a read of reg3 returns its prior value 0x1234.
- Streaming: 32 consecutive cycles reading addresses 0..31 on port A and 31..0 on port B, with regs preloaded to value=index*0x1111 -> each valid cycle returns the matching value, except index 31 returns 0.
